// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Brief    : Instruction-fetch stage. Owns the PC and the IF/ID register, and
//            applies EX-stage redirects from Branch_Unit. Optional fetch/branch
//            statistics are enabled by defining BRANCH_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             NextPCSrc,
    input  logic [XLEN-1:0]  BrTarget,
    input  logic             StallF,
    input  logic [31:0]      InstrMem,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PC_D,
    output logic [XLEN-1:0]  PCInc_D,
    output logic [31:0]      Instr_D,
    output logic             Valid_D,
`ifdef BRANCH_STATS_EN
    output logic [31:0]      BrTakenCnt,
    output logic [31:0]      FetchCnt,
`endif
    output logic             FlushE
);

    localparam logic [XLEN-1:0] c_pc_step    = XLEN'(4);
    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pcinc_d;
    logic [31:0]     r_instr_d;
    logic            r_valid_d;

    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_target;
    logic            w_load_valid;

    // Sequential increment wraps naturally modulo 2^XLEN.
    assign w_pc_inc     = r_pc + c_pc_step;
    assign w_target     = BrTarget & c_align_mask;
    assign w_load_valid = ~rst & ~NextPCSrc & ~StallF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (NextPCSrc) begin
            r_pc <= w_target;
        end else if (!StallF) begin
            r_pc <= w_pc_inc;
        end
    end

    // A redirect squashes the wrong-path word even while the front end is stalled.
    always_ff @(posedge clk) begin
        if (rst || NextPCSrc) begin
            r_pc_d    <= '0;
            r_pcinc_d <= '0;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else if (!StallF) begin
            r_pc_d    <= r_pc;
            r_pcinc_d <= w_pc_inc;
            r_instr_d <= InstrMem;
            r_valid_d <= 1'b1;
        end
    end

    assign PC      = r_pc;
    assign PC_D    = r_pc_d;
    assign PCInc_D = r_pcinc_d;
    assign Instr_D = r_instr_d;
    assign Valid_D = r_valid_d;
    assign FlushE  = NextPCSrc & ~rst;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_taken_cnt;
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_taken_cnt <= '0;
            r_fetch_cnt    <= '0;
        end else begin
            if (NextPCSrc && (r_br_taken_cnt != 32'hFFFF_FFFF)) begin
                r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
            end
            if (w_load_valid && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign BrTakenCnt = r_br_taken_cnt;
    assign FetchCnt   = r_fetch_cnt;
`else
    logic w_unused;
    assign w_unused = w_load_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Directed self-checking bench for fetch_pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        NextPCSrc;
    logic [31:0] BrTarget;
    logic        StallF;
    logic [31:0] InstrMem;
    logic [31:0] PC;
    logic [31:0] PC_D;
    logic [31:0] PCInc_D;
    logic [31:0] Instr_D;
    logic        Valid_D;
    logic        FlushE;
`ifdef BRANCH_STATS_EN
    logic [31:0] BrTakenCnt;
    logic [31:0] FetchCnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    fetch_pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .NextPCSrc (NextPCSrc),
        .BrTarget  (BrTarget),
        .StallF    (StallF),
        .InstrMem  (InstrMem),
        .PC        (PC),
        .PC_D      (PC_D),
        .PCInc_D   (PCInc_D),
        .Instr_D   (Instr_D),
        .Valid_D   (Valid_D),
`ifdef BRANCH_STATS_EN
        .BrTakenCnt(BrTakenCnt),
        .FetchCnt  (FetchCnt),
`endif
        .FlushE    (FlushE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: word content derived from its address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign InstrMem = mem(PC);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pcd, input logic [31:0] ins,
                            input logic [31:0] inc, input logic vld);
        chk({tag, ".PC_D"},    PC_D,    pcd);
        chk({tag, ".Instr_D"}, Instr_D, ins);
        chk({tag, ".PCInc_D"}, PCInc_D, inc);
        chk({tag, ".Valid_D"}, {31'd0, Valid_D}, {31'd0, vld});
    endtask

    initial begin
        rst       = 1'b1;
        NextPCSrc = 1'b0;
        BrTarget  = 32'h0;
        StallF    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst.PC", PC, 32'h0);
        chk_ifid("rst", 32'h0, 32'h13, 32'h0, 1'b0);
        chk("rst.FlushE", {31'd0, FlushE}, 32'h0);
        NextPCSrc = 1'b1;
        #1;
        chk("rst.FlushE_redir", {31'd0, FlushE}, 32'h0);
        NextPCSrc = 1'b0;

        // 1: free run after reset
        rst = 1'b0;
        tick();
        chk("t1.PC4", PC, 32'h4);
        chk_ifid("t1.e1", 32'h0, mem(32'h0), 32'h4, 1'b1);
        tick();
        chk("t1.PC8", PC, 32'h8);
        chk_ifid("t1.e2", 32'h4, mem(32'h4), 32'h8, 1'b1);
        tick();
        chk("t1.PCC", PC, 32'hC);
        tick();
        chk("t1.PC10", PC, 32'h10);
        chk_ifid("t1.e4", 32'hC, mem(32'hC), 32'h10, 1'b1);

        // 2: redirect to 0x20 (low bits dropped), then branch 0x20 -> 0x14
        NextPCSrc = 1'b1;
        BrTarget  = 32'h23;
        tick();
        chk("t2.PC20", PC, 32'h20);
        NextPCSrc = 1'b1;
        BrTarget  = 32'h14;
        #1;
        chk("t2.FlushE", {31'd0, FlushE}, 32'h1);
        tick();
        chk("t2.PC14", PC, 32'h14);
        chk_ifid("t2.flush", 32'h0, 32'h13, 32'h0, 1'b0);
        NextPCSrc = 1'b0;
        #1;
        chk("t2.FlushE_off", {31'd0, FlushE}, 32'h0);
        tick();
        chk("t2.PC18", PC, 32'h18);
        chk_ifid("t2.tgt", 32'h14, mem(32'h14), 32'h18, 1'b1);

        // 3: stall for 3 cycles at PC=0x40
        NextPCSrc = 1'b1;
        BrTarget  = 32'h3C;
        tick();
        NextPCSrc = 1'b0;
        tick();
        chk("t3.PC40", PC, 32'h40);
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3.stall.PC", PC, 32'h40);
            chk_ifid("t3.stall", 32'h3C, mem(32'h3C), 32'h40, 1'b1);
        end
        StallF = 1'b0;
        tick();
        chk("t3.PC44", PC, 32'h44);
        chk_ifid("t3.resume", 32'h40, mem(32'h40), 32'h44, 1'b1);

        // 4: redirect wins over stall
        StallF    = 1'b1;
        NextPCSrc = 1'b1;
        BrTarget  = 32'hFF5F_F0EF;
        #1;
        chk("t4.FlushE", {31'd0, FlushE}, 32'h1);
        tick();
        chk("t4.PC", PC, 32'hFF5F_F0EC);
        chk_ifid("t4.flush", 32'h0, 32'h13, 32'h0, 1'b0);
        StallF = 1'b0;

        // 5: wrap-around at the top of the address space
        BrTarget = 32'hFFFF_FFFF;
        tick();
        chk("t5.PCtop", PC, 32'hFFFF_FFFC);
        NextPCSrc = 1'b0;
        tick();
        chk("t5.PCwrap", PC, 32'h0);
        chk_ifid("t5.top", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 32'h0, 1'b1);
        tick();
        chk("t5.PC4", PC, 32'h4);
        chk_ifid("t5.zero", 32'h0, mem(32'h0), 32'h4, 1'b1);

        // 6: reset during a redirect
        NextPCSrc = 1'b1;
        BrTarget  = 32'h100;
        rst       = 1'b1;
        #1;
        chk("t6.FlushE", {31'd0, FlushE}, 32'h0);
        tick();
        chk("t6.PC", PC, 32'h0);
        chk_ifid("t6", 32'h0, 32'h13, 32'h0, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("t6.BrTakenCnt", BrTakenCnt, 32'h0);
        chk("t6.FetchCnt", FetchCnt, 32'h0);
`endif
        rst       = 1'b0;
        NextPCSrc = 1'b0;
        tick();
        chk("t6.PCafter", PC, 32'h4);
        chk_ifid("t6.after", 32'h0, mem(32'h0), 32'h4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
